// File: rtl/iomem_arbiter.sv
// Two-master arbiter in front of a single picosoc-style iomem slave port.
// Grant is held for a whole transaction; a watchdog completes accesses the slave never acknowledges.
module iomem_arbiter #(
    parameter bit          FIXED_PRIO_M1  = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err,
    input  logic        err_clr
);
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, BUSY_M0, BUSY_M1} state_t;

    state_t        state_q;
    logic          last_q;      // 0 = M0 served last, 1 = M1
    logic [TW-1:0] timer_q;
    logic          err_q;

    logic busy, sel_m1, cur_valid, done, expire, pick_m1;

    assign busy      = (state_q != IDLE);
    assign sel_m1    = (state_q == BUSY_M1);
    assign cur_valid = sel_m1 ? m1_valid : m0_valid;
    assign done      = busy && cur_valid && s_ready;
    assign expire    = WDOG_EN && busy && cur_valid && !s_ready && (timer_q == TMAX);
    // Tie goes to M1 under fixed priority, otherwise to whoever was not served last.
    assign pick_m1   = m1_valid && (!m0_valid || FIXED_PRIO_M1 || !last_q);

    assign grant       = {state_q == BUSY_M1, state_q == BUSY_M0};
    assign timeout_err = err_q;

    assign s_valid = busy && cur_valid && !expire;
    assign s_addr  = !busy ? 32'h0 : (sel_m1 ? m1_addr  : m0_addr);
    assign s_wdata = !busy ? 32'h0 : (sel_m1 ? m1_wdata : m0_wdata);
    assign s_wstrb = !busy ? 4'h0  : (sel_m1 ? m1_wstrb : m0_wstrb);

    assign m0_ready = (state_q == BUSY_M0) && (done || expire);
    assign m1_ready = (state_q == BUSY_M1) && (done || expire);
    assign m0_rdata = (state_q != BUSY_M0) ? 32'h0 : (expire ? TIMEOUT_DATA : s_rdata);
    assign m1_rdata = (state_q != BUSY_M1) ? 32'h0 : (expire ? TIMEOUT_DATA : s_rdata);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timer_q <= '0;
                    if (m0_valid || m1_valid)
                        state_q <= pick_m1 ? BUSY_M1 : BUSY_M0;
                end
                default: begin
                    if (!cur_valid) begin
                        // master abandoned the request: release without touching last
                        state_q <= IDLE;
                        timer_q <= '0;
                    end else if (s_ready || expire) begin
                        state_q <= IDLE;
                        last_q  <= sel_m1;
                        timer_q <= '0;
                    end else if (WDOG_EN) begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
            endcase
            if (expire)
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed bench for iomem_arbiter: round-robin instance (watchdog 8) with a completion
// scoreboard, plus a fixed-priority instance for tie behaviour.
module tb_iomem_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        m0_valid = 0, m1_valid = 0, s_ready = 0, err_clr = 0;
    logic [3:0]  m0_wstrb = 0, m1_wstrb = 0;
    logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0, s_rdata = 0;
    logic        m0_ready, m1_ready, s_valid, timeout_err;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;

    logic        b_m0_valid = 0, b_m1_valid = 0, b_s_ready = 0;
    logic        b_m0_ready, b_m1_ready, b_s_valid, b_terr;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
    logic [3:0]  b_s_wstrb;
    logic [1:0]  b_grant;

    iomem_arbiter #(.FIXED_PRIO_M1(1'b0), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr));

    iomem_arbiter #(.FIXED_PRIO_M1(1'b1), .TIMEOUT_CYCLES(8)) dut_fp (
        .clk(clk), .resetn(resetn),
        .m0_valid(b_m0_valid), .m0_ready(b_m0_ready), .m0_wstrb(4'h0), .m0_addr(32'h0),
        .m0_wdata(32'h0), .m0_rdata(b_m0_rdata),
        .m1_valid(b_m1_valid), .m1_ready(b_m1_ready), .m1_wstrb(4'h0), .m1_addr(32'h4),
        .m1_wdata(32'h0), .m1_rdata(b_m1_rdata),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_wstrb(b_s_wstrb), .s_addr(b_s_addr),
        .s_wdata(b_s_wdata), .s_rdata(32'h0),
        .grant(b_grant), .timeout_err(b_terr), .err_clr(1'b0));

    typedef struct packed { logic m; logic [31:0] d; } exp_t;
    exp_t exp_q[$];
    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Completions on the round-robin instance are matched against the scoreboard.
    always @(negedge clk) begin
        if (resetn && (m0_ready || m1_ready)) begin
            exp_t e;
            total++;
            assert (exp_q.size() != 0 && !(m0_ready && m1_ready)) else begin
                bad++;
                $error("FAIL sb_unexpected: got ready=%b%b want queued single completion", m1_ready, m0_ready);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                assert ({m1_ready, m0_ready} === (e.m ? 2'b10 : 2'b01) &&
                        (e.m ? m1_rdata : m0_rdata) === e.d) else begin
                    bad++;
                    $error("FAIL sb_data: got ready=%b%b rdata=%h want m%0d rdata=%h",
                           m1_ready, m0_ready, e.m ? m1_rdata : m0_rdata, e.m, e.d);
                end
            end
        end
    end

    // Wait for a grant, check owner, complete after lat BUSY cycles, then drop that master's valid.
    task automatic serve(input int lat, input logic [31:0] rd, input logic [1:0] exp_g);
        int n = 0;
        logic [1:0] g;
        while (grant == 2'b00 && n < 20) begin tick(); n++; end
        chk("serve_grant", {30'h0, grant}, {30'h0, exp_g});
        g = grant;
        repeat (lat - 1) tick();
        s_ready = 1'b1;
        s_rdata = rd;
        exp_q.push_back('{m: g[1], d: rd});
        tick();
        s_ready = 1'b0;
        s_rdata = 32'h0;
        if (g[1]) m1_valid = 1'b0; else m0_valid = 1'b0;
    endtask

    initial begin
        logic [1:0] tie_exp;
        #2;
        chk("rst_grant", {30'h0, grant}, 32'h0);
        chk("rst_s_valid", {31'h0, s_valid}, 32'h0);
        chk("rst_m0_ready", {31'h0, m0_ready}, 32'h0);
        chk("rst_m0_rdata", m0_rdata, 32'h0);
        chk("rst_terr", {31'h0, timeout_err}, 32'h0);
        tick(); resetn = 1'b1; tick();

        // Basic M0 read, slave answers on the second BUSY cycle
        m0_valid = 1'b1; m0_addr = 32'h0300_0010; m0_wstrb = 4'h0;
        #1 chk("t1_sval_idle", {31'h0, s_valid}, 32'h0);
        tick();
        chk("t1_grant", {30'h0, grant}, 32'h1);
        chk("t1_s_valid", {31'h0, s_valid}, 32'h1);
        chk("t1_s_addr", s_addr, 32'h0300_0010);
        chk("t1_m0_ready_early", {31'h0, m0_ready}, 32'h0);
        tick();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        exp_q.push_back('{m: 1'b0, d: 32'h1234_5678});
        #1 chk("t1_m0_ready", {31'h0, m0_ready}, 32'h1);
        chk("t1_m0_rdata", m0_rdata, 32'h1234_5678);
        tick();
        s_ready = 1'b0; s_rdata = 32'h0; m0_valid = 1'b0;
        chk("t1_grant_idle", {30'h0, grant}, 32'h0);
        chk("t1_ready_pulse", {31'h0, m0_ready}, 32'h0);
        tick();

        // Fresh reset so the first tie goes to M0
        resetn = 1'b0; tick(); resetn = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            m0_valid = 1'b1; m1_valid = 1'b1; m0_addr = 32'h100 + i; m1_addr = 32'h200 + i;
            tie_exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            serve(1, 32'hA000_0000 + i, tie_exp);
            m0_valid = 1'b0; m1_valid = 1'b0;
            tick();
        end

        // M1 write while M0 waits
        m1_valid = 1'b1; m1_wstrb = 4'b0011; m1_addr = 32'h0200_0004; m1_wdata = 32'hAABB_CCDD;
        tick();
        m0_valid = 1'b1; m0_wstrb = 4'h0; m0_addr = 32'h0300_0020;
        chk("w_grant", {30'h0, grant}, 32'h2);
        chk("w_s_wstrb", {28'h0, s_wstrb}, 32'h3);
        chk("w_s_wdata", s_wdata, 32'hAABB_CCDD);
        chk("w_s_addr", s_addr, 32'h0200_0004);
        tick();
        chk("w_m0_blocked", {31'h0, m0_ready}, 32'h0);
        serve(2, 32'h0, 2'b10);
        chk("w_m0_still_blocked", {31'h0, m0_ready}, 32'h0);
        serve(1, 32'hCAFE_0001, 2'b01);
        m1_wstrb = 4'h0;
        tick();

        // Watchdog expiry on the 8th BUSY cycle
        m0_valid = 1'b1; m0_addr = 32'h0300_0040;
        tick();
        repeat (6) tick();
        chk("wd_c7_ready", {31'h0, m0_ready}, 32'h0);
        chk("wd_c7_s_valid", {31'h0, s_valid}, 32'h1);
        exp_q.push_back('{m: 1'b0, d: 32'hFFFF_FFFF});
        tick();
        chk("wd_c8_ready", {31'h0, m0_ready}, 32'h1);
        chk("wd_c8_rdata", m0_rdata, 32'hFFFF_FFFF);
        chk("wd_c8_s_valid", {31'h0, s_valid}, 32'h0);
        tick();
        m0_valid = 1'b0;
        chk("wd_err_set", {31'h0, timeout_err}, 32'h1);
        chk("wd_grant_idle", {30'h0, grant}, 32'h0);
        tick();
        chk("wd_err_sticky", {31'h0, timeout_err}, 32'h1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("wd_err_clr", {31'h0, timeout_err}, 32'h0);
        m0_valid = 1'b1;
        serve(8, 32'h0000_55AA, 2'b01);
        tick();
        chk("wd_c8_normal_noerr", {31'h0, timeout_err}, 32'h0);

        // Protocol abort
        m0_valid = 1'b1;
        tick();
        chk("ab_grant", {30'h0, grant}, 32'h1);
        m0_valid = 1'b0;
        #1 chk("ab_no_ready", {31'h0, m0_ready}, 32'h0);
        tick();
        chk("ab_idle", {30'h0, grant}, 32'h0);

        // Asynchronous reset during BUSY_M1
        m1_valid = 1'b1;
        tick();
        chk("rs_grant_m1", {30'h0, grant}, 32'h2);
        #1 resetn = 1'b0;
        #1 chk("rs_grant_async", {30'h0, grant}, 32'h0);
        chk("rs_s_valid_async", {31'h0, s_valid}, 32'h0);
        m1_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        m0_valid = 1'b1; m1_valid = 1'b1;
        serve(1, 32'h0BAD_0000, 2'b01);
        m1_valid = 1'b0;
        tick();

        // Fixed priority: M1 wins every tie, M0 only once M1 goes idle
        b_m0_valid = 1'b1; b_m1_valid = 1'b1; b_s_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fp_grant_m1", {30'h0, b_grant}, 32'h2);
            chk("fp_m1_ready", {31'h0, b_m1_ready}, 32'h1);
            chk("fp_m0_blocked", {31'h0, b_m0_ready}, 32'h0);
            tick();
            chk("fp_idle", {30'h0, b_grant}, 32'h0);
        end
        b_m1_valid = 1'b0;
        tick();
        chk("fp_grant_m0", {30'h0, b_grant}, 32'h1);
        chk("fp_m0_ready", {31'h0, b_m0_ready}, 32'h1);
        b_m0_valid = 1'b0; b_s_ready = 1'b0;
        tick();

        chk("sb_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
